// File: rtl/text_pkg.sv
// Shared types and constants for the character-cell text buffer.
package text_pkg;

    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic [2:0] {
        OP_CLEAR   = 3'd0,
        OP_NEWLINE = 3'd1,
        OP_HOME    = 3'd2,
        OP_SET_COL = 3'd3,
        OP_SET_ROW = 3'd4
    } opcode_e;

    typedef enum logic {
        ST_CLEARING = 1'b0,
        ST_IDLE     = 1'b1
    } state_e;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, registered read-first read port.
module text_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 7
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Read samples the pre-write contents, giving read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/text_buffer.sv
// Character-cell buffer: command/byte-stream writer on one side, VGA overlay
// cell lookup (1-cycle latency) on the other.
module text_buffer
    import text_pkg::*;
#(
    parameter int unsigned       COL_W      = 4,
    parameter int unsigned       ROW_W      = 4,
    parameter int unsigned       CODE_W     = 7,
    parameter logic [CODE_W-1:0] CLEAR_CODE = CODE_W'(SPACE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROW_W+COL_W-1:0] char_xy,
    output logic [CODE_W-1:0]      char_code,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic                   busy,
    output logic [ROW_W+COL_W-1:0] cursor
);

    localparam int unsigned        XY_W      = ROW_W + COL_W;
    localparam logic [XY_W-1:0]    LAST_CELL = '1;

    state_e              r_state, w_state_nx;
    logic [XY_W-1:0]     r_cnt, w_cnt_nx;
    logic [XY_W-1:0]     r_cursor, w_cursor_nx;
    logic                r_busy, r_wr_ready, r_rd_mask;
    logic                w_xfer;
    logic                w_we;
    logic [XY_W-1:0]     w_waddr;
    logic [CODE_W-1:0]   w_wdata;
    logic [CODE_W-1:0]   w_rd_data;
    logic [ROW_W-1:0]    w_row;
    logic [COL_W-1:0]    w_col;

    assign w_row  = r_cursor[XY_W-1:COL_W];
    assign w_col  = r_cursor[COL_W-1:0];
    assign w_xfer = wr_valid && (r_state == ST_IDLE);

    // Next-state, clear sweep, cursor update and RAM write port.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_cursor_nx = r_cursor;
        w_we        = 1'b0;
        w_waddr     = r_cursor;
        w_wdata     = CODE_W'(wr_data[6:0]);
        case (r_state)
            ST_CLEARING: begin
                w_we     = 1'b1;
                w_waddr  = r_cnt;
                w_wdata  = CLEAR_CODE;
                w_cnt_nx = r_cnt + XY_W'(1);
                if (r_cnt == LAST_CELL) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_xfer) begin
                    if (!wr_data[7]) begin
                        w_we        = 1'b1;
                        w_cursor_nx = r_cursor + XY_W'(1);
                    end else begin
                        case (opcode_e'(wr_data[6:4]))
                            OP_CLEAR: begin
                                w_state_nx  = ST_CLEARING;
                                w_cnt_nx    = '0;
                                w_cursor_nx = '0;
                            end
                            OP_NEWLINE: w_cursor_nx = {w_row + ROW_W'(1), COL_W'(0)};
                            OP_HOME:    w_cursor_nx = '0;
                            OP_SET_COL: w_cursor_nx = {w_row, COL_W'(wr_data[3:0])};
                            OP_SET_ROW: w_cursor_nx = {ROW_W'(wr_data[3:0]), w_col};
                            default:    w_cursor_nx = r_cursor;
                        endcase
                    end
                end
            end
            default: w_state_nx = ST_CLEARING;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEARING;
            r_cnt      <= '0;
            r_cursor   <= '0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
            r_rd_mask  <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_cursor   <= w_cursor_nx;
            r_busy     <= (w_state_nx == ST_CLEARING);
            r_wr_ready <= (w_state_nx == ST_IDLE);
            // Masks the RAM read issued in a clearing cycle so the overlay sees blanks.
            r_rd_mask  <= (r_state == ST_CLEARING);
        end
    end

    text_ram #(
        .ADDR_W (XY_W),
        .DATA_W (CODE_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_we),
        .i_wr_addr (w_waddr),
        .i_wr_data (w_wdata),
        .i_rd_addr (char_xy),
        .o_rd_data (w_rd_data)
    );

    assign char_code = r_rd_mask ? CLEAR_CODE : w_rd_data;
    assign wr_ready  = r_wr_ready;
    assign busy      = r_busy;
    assign cursor    = r_cursor;

endmodule

// File: tb/tb_text_buffer.sv
// Directed self-checking bench for text_buffer at default parameters.
module tb_text_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic [7:0] cursor;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    text_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .char_xy   (char_xy),
        .char_code (char_code),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .cursor    (cursor)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a byte, wait (bounded) for ready, and complete one transfer.
    task automatic wr_byte(input logic [7:0] b);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready && n < 400) begin
            tick();
            n++;
        end
        check("wr_ready_timeout", 32'(n < 400), 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    // Count cycles until wr_ready rises (bounded).
    task automatic count_clear(output int n);
        n = 0;
        while (!wr_ready && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;

        rst      = 1'b1;
        char_xy  = 8'h00;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        #3;
        check("rst_busy",     32'(busy),      32'd1);
        check("rst_wr_ready", 32'(wr_ready),  32'd0);
        check("rst_cursor",   32'(cursor),    32'h00);
        check("rst_char",     32'(char_code), 32'h20);
        tick();
        tick();
        rst = 1'b0;

        // Power-up clear lasts exactly 256 cycles
        count_clear(n);
        check("init_clear_len", 32'(n),      32'd256);
        check("init_busy_low",  32'(busy),   32'd0);
        check("init_cursor",    32'(cursor), 32'h00);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            char_xy = 8'(i);
            tick();
            if (char_code !== 7'h20) bad++;
        end
        check("all_cells_space", 32'(bad), 32'd0);

        // Printable stream
        wr_byte(8'h57);
        wr_byte(8'h59);
        wr_byte(8'h47);
        check("stream_cursor", 32'(cursor), 32'h03);
        char_xy = 8'h01; tick();
        check("cell01", 32'(char_code), 32'h59);
        char_xy = 8'h00; tick();
        check("cell00", 32'(char_code), 32'h57);
        char_xy = 8'h02; tick();
        check("cell02", 32'(char_code), 32'h47);

        // Read-first collision at cell 0x03
        char_xy  = 8'h03;
        wr_valid = 1'b1;
        wr_data  = 8'h41;
        tick();
        wr_valid = 1'b0;
        check("rf_old", 32'(char_code), 32'h20);
        tick();
        check("rf_new", 32'(char_code), 32'h41);
        check("rf_cursor", 32'(cursor), 32'h04);

        // Last cell and full wrap
        wr_byte(8'hCF);
        wr_byte(8'hBF);
        check("set_rc_ff", 32'(cursor), 32'hFF);
        wr_byte(8'h41);
        check("wrap_cursor", 32'(cursor), 32'h00);
        char_xy = 8'hFF; tick();
        check("cellFF", 32'(char_code), 32'h41);

        // NEWLINE, HOME, reserved opcodes
        wr_byte(8'hC2);
        wr_byte(8'hB5);
        check("set_25", 32'(cursor), 32'h25);
        wr_byte(8'h90);
        check("nl_25", 32'(cursor), 32'h30);
        wr_byte(8'hCF);
        wr_byte(8'hB3);
        wr_byte(8'h90);
        check("nl_F3", 32'(cursor), 32'h00);
        wr_byte(8'hC7);
        wr_byte(8'hBA);
        check("set_7A", 32'(cursor), 32'h7A);
        wr_byte(8'hA0);
        check("home", 32'(cursor), 32'h00);
        wr_byte(8'hC7);
        wr_byte(8'hBA);
        wr_valid = 1'b1;
        wr_data  = 8'hE0;
        check("op6_ready_pre", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        check("op6_cursor", 32'(cursor),   32'h7A);
        check("op6_ready",  32'(wr_ready), 32'd1);
        wr_byte(8'hD0);
        wr_byte(8'hF0);
        check("op5_7_cursor", 32'(cursor), 32'h7A);

        // CLEAR with a held printable byte behind it
        char_xy  = 8'hFF;
        wr_valid = 1'b1;
        wr_data  = 8'h80;
        tick();
        wr_data  = 8'h45;
        check("clr_char_first", 32'(char_code), 32'h41);
        check("clr_cursor",     32'(cursor),    32'h00);
        check("clr_busy",       32'(busy),      32'd1);
        n   = 0;
        bad = 0;
        while (!wr_ready && n < 400) begin
            tick();
            n++;
            if (char_code !== 7'h20) bad++;
        end
        check("clr_len",      32'(n),   32'd256);
        check("clr_char_sp",  32'(bad), 32'd0);
        tick();
        wr_valid = 1'b0;
        check("held_cursor", 32'(cursor), 32'h01);
        char_xy = 8'h00; tick();
        check("held_cell00", 32'(char_code), 32'h45);
        char_xy = 8'hFF; tick();
        check("clr_cellFF", 32'(char_code), 32'h20);

        // Asynchronous reset from IDLE with non-reset outputs
        char_xy = 8'h00; tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy),      32'd1);
        check("arst_ready",  32'(wr_ready),  32'd0);
        check("arst_cursor", 32'(cursor),    32'h00);
        check("arst_char",   32'(char_code), 32'h20);
        tick();
        rst = 1'b0;

        // Reset mid-clear restarts the sweep
        for (int i = 0; i < 100; i++) tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_busy",   32'(busy),     32'd1);
        check("mid_ready",  32'(wr_ready), 32'd0);
        check("mid_cursor", 32'(cursor),   32'h00);
        tick();
        tick();
        rst = 1'b0;
        count_clear(n);
        check("mid_clear_len", 32'(n), 32'd256);
        char_xy = 8'h00; tick();
        check("mid_cell00", 32'(char_code), 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
